// File: rtl/cacheline_burst_adapter.sv
// Splits one cacheline read/write from the cache arbiter into a BURST_LEN-beat burst on pmem.
// Optional BURST_TIMEOUT_EN adds a per-beat wait watchdog that flags err and ends the burst.
module cacheline_burst_adapter #(
  parameter int BURST_LEN      = 4,
  parameter int BEAT_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        line_read,
  input  logic                        line_write,
  input  logic [31:0]                 line_address,
  input  logic [BURST_LEN*BEAT_W-1:0] line_wdata,
  output logic                        line_resp,
  output logic [BURST_LEN*BEAT_W-1:0] line_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [31:0]                 pmem_address,
  output logic [BEAT_W-1:0]           pmem_wdata,
  input  logic [BEAT_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp,
  output logic                        err
);

  localparam int LINE_W = BURST_LEN * BEAT_W;
  localparam int CNT_W  = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0] rbuf_q, rbuf_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [26:0]       addr_q, addr_d;
  logic              last_beat;
  logic              timeout;

  // Offset bits are not part of the line address.
  logic unused_offset;
  assign unused_offset = ^line_address[4:0];

  assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));

`ifdef BURST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  // Counter idles at zero, so entering READ/WRITE starts it from a clean value.
  always_comb begin
    wait_cnt_d = '0;
    err_d      = err_q;
    timeout    = 1'b0;
    if ((state_q == READ || state_q == WRITE) && !pmem_resp) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_W'(TIMEOUT_CYCLES)) begin
        timeout = 1'b1;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // NOTE: every *_d gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rbuf_d     = rbuf_q;
    wbuf_d     = wbuf_q;
    addr_d     = addr_q;

    unique case (state_q)
      IDLE: begin
        if (line_write) begin
          addr_d     = line_address[31:5];
          wbuf_d     = line_wdata;
          beat_cnt_d = '0;
          state_d    = WRITE;
        end else if (line_read) begin
          addr_d     = line_address[31:5];
          beat_cnt_d = '0;
          state_d    = READ;
        end
      end
      READ: begin
        if (pmem_resp) begin
          rbuf_d[beat_cnt_q*BEAT_W +: BEAT_W] = pmem_rdata;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = DONE;
          end
        end else if (timeout) begin
          beat_cnt_d = '0;
          state_d    = DONE;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = DONE;
          end
        end else if (timeout) begin
          beat_cnt_d = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pmem_* stay at zero outside an active burst.
  always_comb begin
    line_resp    = (state_q == DONE);
    line_rdata   = rbuf_q;
    pmem_read    = (state_q == READ);
    pmem_write   = (state_q == WRITE);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == READ || state_q == WRITE) begin
      pmem_address = {addr_q, 5'b0};
    end
    if (state_q == WRITE) begin
      pmem_wdata = wbuf_q[beat_cnt_q*BEAT_W +: BEAT_W];
    end
  end

  // NOTE: both line buffers are reset too, because line_rdata must read zero after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rbuf_q     <= '0;
      wbuf_q     <= '0;
      addr_q     <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values regardless of order.
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rbuf_q     <= rbuf_d;
      wbuf_q     <= wbuf_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed bench for cacheline_burst_adapter: scoreboard queues hold expected lines and write
// beats, popped as the DUT completes a line or presents a beat. Timeout case under BURST_TIMEOUT_EN.
module tb_cacheline_burst_adapter;

  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = 64;
  localparam int LINE_W    = BURST_LEN * BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              line_read = 1'b0;
  logic              line_write = 1'b0;
  logic [31:0]       line_address = '0;
  logic [LINE_W-1:0] line_wdata = '0;
  logic              line_resp;
  logic [LINE_W-1:0] line_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic              err;

  always #5 clk = ~clk;

  cacheline_burst_adapter #(
    .BURST_LEN     (BURST_LEN),
    .BEAT_W        (BEAT_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_address(line_address),
    .line_wdata  (line_wdata),
    .line_resp   (line_resp),
    .line_rdata  (line_rdata),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .err         (err)
  );

  logic [LINE_W-1:0] rd_sb[$];
  logic [BEAT_W-1:0] wr_sb[$];
  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called in the cycle the last beat's resp has been taken: expects the DONE pulse.
  task automatic finish_burst(input bit is_read, input bit stray_resp);
    logic [LINE_W-1:0] exp_line;
    check("done_resp", line_resp, 1'b1);
    check("done_no_read", pmem_read, 1'b0);
    check("done_no_write", pmem_write, 1'b0);
    if (is_read) begin
      exp_line = rd_sb.pop_front();
      check("rd_line", line_rdata, exp_line);
    end
    pmem_resp = stray_resp;
    step();
    pmem_resp = 1'b0;
    check("resp_single_pulse", line_resp, 1'b0);
    check("idle_no_read", pmem_read, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                         input int waits, input bit stray_in_done);
    rd_sb.push_back(line);
    line_address = addr;
    line_read    = 1'b1;
    step();
    line_read    = 1'b0;
    line_address = ~addr;
    for (int k = 0; k < BURST_LEN; k++) begin
      for (int w = 0; w < waits; w++) begin
        check("rd_wait_no_resp", line_resp, 1'b0);
        step();
      end
      check("rd_pmem_read", pmem_read, 1'b1);
      check("rd_no_write", pmem_write, 1'b0);
      check("rd_addr", pmem_address, {addr[31:5], 5'b0});
      pmem_rdata = line[k*BEAT_W +: BEAT_W];
      pmem_resp  = 1'b1;
      step();
      pmem_resp  = 1'b0;
      pmem_rdata = {$urandom, $urandom};
    end
    finish_burst(1'b1, stray_in_done);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                          input int waits, input bit also_read, output int write_cycles);
    write_cycles = 0;
    for (int k = 0; k < BURST_LEN; k++) wr_sb.push_back(line[k*BEAT_W +: BEAT_W]);
    line_address = addr;
    line_wdata   = line;
    line_write   = 1'b1;
    line_read    = also_read;
    step();
    line_write   = 1'b0;
    line_read    = 1'b0;
    line_wdata   = rand_line();
    line_address = ~addr;
    for (int k = 0; k < BURST_LEN; k++) begin
      for (int w = 0; w < waits; w++) begin
        check("wr_hold_beat", pmem_wdata, wr_sb[0]);
        check("wr_no_read", pmem_read, 1'b0);
        if (pmem_write) write_cycles++;
        step();
      end
      check("wr_pmem_write", pmem_write, 1'b1);
      check("wr_no_read", pmem_read, 1'b0);
      check("wr_addr", pmem_address, {addr[31:5], 5'b0});
      if (pmem_write) write_cycles++;
      check("wr_beat", pmem_wdata, wr_sb.pop_front());
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
    end
    finish_burst(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [LINE_W-1:0] line_a;
    logic [LINE_W-1:0] line_b;
    logic [LINE_W-1:0] line_c;
    int wcyc;

    // Reset: all outputs zero while and right after reset.
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_line_resp", line_resp, 1'b0);
    check("rst_line_rdata", line_rdata, '0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_err", err, 1'b0);

    // 1: read at 0x1234, back-to-back beats.
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, line_a, 0, 1'b0);

    // 2: write, beat k = k+1, two wait cycles before each resp; accepted right after DONE.
    line_b = {64'd4, 64'd3, 64'd2, 64'd1};
    do_write(32'h0000_8040, line_b, 2, 1'b0, wcyc);
    check("wr_held_cycles", wcyc, 12);
    check("wr_keeps_rdata", line_rdata, line_a);

    // 3: simultaneous read and write in IDLE -> write only.
    line_c = rand_line();
    do_write(32'hDEAD_BEEF, line_c, 1, 1'b1, wcyc);
    check("both_held_cycles", wcyc, 8);
    step();
    check("both_read_dropped", pmem_read, 1'b0);
    check("both_rdata_kept", line_rdata, line_a);

    // 4: reset after two read beats aborts the burst.
    line_address = 32'h0000_2000;
    line_read    = 1'b1;
    step();
    line_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pmem_rdata = {2{$urandom}};
      pmem_resp  = 1'b1;
      step();
    end
    pmem_resp = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_pmem_read", pmem_read, 1'b0);
    check("abort_rdata_cleared", line_rdata, '0);
    check("abort_no_resp", line_resp, 1'b0);
    check("abort_addr", pmem_address, '0);
    step();
    check("abort_idle_no_resp", line_resp, 1'b0);
    check("abort_idle_no_read", pmem_read, 1'b0);

    // 5: stray resp in IDLE, then read (stray resp in DONE) and write back-to-back.
    pmem_resp  = 1'b1;
    pmem_rdata = {2{$urandom}};
    step();
    check("stray_no_read", pmem_read, 1'b0);
    check("stray_no_resp", line_resp, 1'b0);
    step();
    pmem_resp = 1'b0;
    check("stray_rdata_kept", line_rdata, '0);
    check("stray_still_idle", line_resp, 1'b0);
    line_a = rand_line();
    do_read(32'h1234_5678, line_a, 1, 1'b1);
    do_write(32'h8765_4320, rand_line(), 0, 1'b0, wcyc);
    check("b2b_write_cycles", wcyc, 4);
    check("b2b_rdata_kept", line_rdata, line_a);
    step();
    check("b2b_idle_no_write", pmem_write, 1'b0);

`ifdef BURST_TIMEOUT_EN
    // 6: memory silent after the first beat -> err and line_resp after 8 idle cycles.
    begin
      int n;
      logic [BEAT_W-1:0] beat0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      beat0        = {$urandom, $urandom};
      line_address = 32'h0000_4000;
      line_read    = 1'b1;
      step();
      line_read  = 1'b0;
      pmem_rdata = beat0;
      pmem_resp  = 1'b1;
      step();
      pmem_resp = 1'b0;
      n = 0;
      while (!line_resp && n < 20) begin
        step();
        n++;
      end
      check("to_latency", n, 8);
      check("to_err_set", err, 1'b1);
      check("to_partial_line", line_rdata, {{(LINE_W - BEAT_W){1'b0}}, beat0});
      repeat (3) step();
      check("to_err_sticky", err, 1'b1);
      check("to_idle", pmem_read, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("to_err_cleared", err, 1'b0);
    end
`else
    check("err_tied_low", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
